axis_cfg_arbiter: RTL and testbench

Sequencer and arbiter that drives the `axis` configuration bus (`cfg_addr` / `cfg_data` / `cfg_valid`). It accepts write-stream jobs and read-stream jobs (base address plus length) from two independent requesters and arbitrates between them round-robin. Each accepted job is converted into a fixed three-beat configuration sequence for the `axis_write` or `axis_read` path. A host configuration port is also merged onto the same bus, and it is only ever granted between sequences.

---
 rtl/axis_cfg_arbiter_pkg.sv | 17 +
 rtl/axis_cfg_rr_arb.sv | 29 ++
 rtl/axis_cfg_arbiter.sv | 173 +++++++++++++++++
 tb/tb_axis_cfg_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_cfg_arbiter_pkg.sv
// Shared definitions for the axis configuration arbiter: FSM state encodings
// and the default beat addresses that the axis block decodes as well.
package axis_cfg_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_LEN  = 2'd2,
    ST_GO   = 2'd3
  } arb_state_e;

  localparam int DEF_CFG_ID_WR = 1;
  localparam int DEF_CFG_ID_RD = 2;
  localparam int DEF_CFG_ADDR  = 23;
  localparam int DEF_CFG_DATA  = 24;

endpackage

// File: rtl/axis_cfg_rr_arb.sv
// Two-way round-robin picker; req[0] is the write requester, req[1] the read
// requester. The last-grant flag only moves when the caller says a grant counted.
module axis_cfg_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_rd;

  // A tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_rd ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_rd <= 1'b1;
    end else if (advance) begin
      last_rd <= grant[1];
    end
  end

endmodule

// File: rtl/axis_cfg_arbiter.sv
// Turns write/read stream jobs and host beats into axis configuration beats.
// Define AXIS_CFG_ARB_STATS_EN to build the per-direction job counters.
module axis_cfg_arbiter
  import axis_cfg_arbiter_pkg::*;
#(
  parameter int CFG_ID_WR  = DEF_CFG_ID_WR,
  parameter int CFG_ID_RD  = DEF_CFG_ID_RD,
  parameter int CFG_ADDR   = DEF_CFG_ADDR,
  parameter int CFG_DATA   = DEF_CFG_DATA,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_DWIDTH = 32,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_cmd_valid,
  output logic                  wr_cmd_ready,
  input  logic [CFG_DWIDTH-1:0] wr_cmd_addr,
  input  logic [CFG_DWIDTH-1:0] wr_cmd_len,
  input  logic                  rd_cmd_valid,
  output logic                  rd_cmd_ready,
  input  logic [CFG_DWIDTH-1:0] rd_cmd_addr,
  input  logic [CFG_DWIDTH-1:0] rd_cmd_len,
  input  logic                  host_cfg_valid,
  output logic                  host_cfg_ready,
  input  logic [CFG_AWIDTH-1:0] host_cfg_addr,
  input  logic [CFG_DWIDTH-1:0] host_cfg_data,
  output logic [CFG_AWIDTH-1:0] cfg_addr,
  output logic [CFG_DWIDTH-1:0] cfg_data,
  output logic                  cfg_valid,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] wr_jobs,
  output logic [STAT_WIDTH-1:0] rd_jobs
);

  arb_state_e state, state_next;

  logic [1:0]            req, grant;
  logic                  host_take, accept, job_start;
  logic [CFG_DWIDTH-1:0] sel_addr, sel_len;
  logic [CFG_DWIDTH-1:0] job_addr, job_len;
  logic                  job_is_rd;
  logic [CFG_AWIDTH-1:0] cfg_addr_d;
  logic [CFG_DWIDTH-1:0] cfg_data_d;
  logic                  cfg_valid_d;

  // The host only gets in between sequences and then blocks both job requesters.
  assign host_take      = (state == ST_IDLE) && host_cfg_valid;
  assign req            = (state == ST_IDLE && !host_cfg_valid) ? {rd_cmd_valid, wr_cmd_valid} : 2'b00;
  assign host_cfg_ready = host_take;
  assign wr_cmd_ready   = grant[0];
  assign rd_cmd_ready   = grant[1];

  assign sel_addr  = grant[1] ? rd_cmd_addr : wr_cmd_addr;
  assign sel_len   = grant[1] ? rd_cmd_len  : wr_cmd_len;
  assign accept    = |grant;
  // Zero-length jobs are swallowed without touching the round-robin history.
  assign job_start = accept && (sel_len != '0);

  axis_cfg_rr_arb u_rr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (job_start),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (job_start) state_next = ST_ADDR;
      ST_ADDR: state_next = ST_LEN;
      ST_LEN:  state_next = ST_GO;
      ST_GO:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Beat contents are chosen for the state being entered so they can be registered.
  always_comb begin
    cfg_valid_d = 1'b0;
    cfg_addr_d  = '0;
    cfg_data_d  = '0;
    case (state_next)
      ST_IDLE: begin
        if (host_take) begin
          cfg_valid_d = 1'b1;
          cfg_addr_d  = host_cfg_addr;
          cfg_data_d  = host_cfg_data;
        end
      end
      ST_ADDR: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CFG_AWIDTH'(CFG_ADDR);
        cfg_data_d  = sel_addr;
      end
      ST_LEN: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = CFG_AWIDTH'(CFG_DATA);
        cfg_data_d  = job_len;
      end
      ST_GO: begin
        cfg_valid_d = 1'b1;
        cfg_addr_d  = job_is_rd ? CFG_AWIDTH'(CFG_ID_RD) : CFG_AWIDTH'(CFG_ID_WR);
      end
      default: begin
        cfg_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_valid <= 1'b0;
      cfg_addr  <= '0;
      cfg_data  <= '0;
      busy      <= 1'b0;
    end else begin
      cfg_valid <= cfg_valid_d;
      cfg_addr  <= cfg_addr_d;
      cfg_data  <= cfg_data_d;
      busy      <= (state_next != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      job_addr  <= '0;
      job_len   <= '0;
      job_is_rd <= 1'b0;
    end else if (job_start) begin
      job_addr  <= sel_addr;
      job_len   <= sel_len;
      job_is_rd <= grant[1];
    end
  end

`ifdef AXIS_CFG_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] wr_cnt, rd_cnt;

  // Counted as the GO beat is issued, so an abandoned sequence never counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (state_next == ST_GO) begin
      if (job_is_rd) begin
        rd_cnt <= rd_cnt + STAT_WIDTH'(1);
      end else begin
        wr_cnt <= wr_cnt + STAT_WIDTH'(1);
      end
    end
  end

  assign wr_jobs = wr_cnt;
  assign rd_jobs = rd_cnt;
`else
  assign wr_jobs = '0;
  assign rd_jobs = '0;
`endif

  logic unused_job_addr;
  assign unused_job_addr = ^job_addr;

endmodule

// File: tb/tb_axis_cfg_arbiter.sv
// Self-checking bench for axis_cfg_arbiter: directed scenarios plus random
// traffic, compared against a beat-schedule model of the configuration bus.
module tb_axis_cfg_arbiter;

  localparam int STATW = 4;

  logic        clk;
  logic        rst;
  logic        wr_cmd_valid, wr_cmd_ready;
  logic [31:0] wr_cmd_addr, wr_cmd_len;
  logic        rd_cmd_valid, rd_cmd_ready;
  logic [31:0] rd_cmd_addr, rd_cmd_len;
  logic        host_cfg_valid, host_cfg_ready;
  logic [4:0]  host_cfg_addr;
  logic [31:0] host_cfg_data;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        busy;
  logic [STATW-1:0] wr_jobs, rd_jobs;

  axis_cfg_arbiter #(.STAT_WIDTH(STATW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_cmd_valid   (wr_cmd_valid),
    .wr_cmd_ready   (wr_cmd_ready),
    .wr_cmd_addr    (wr_cmd_addr),
    .wr_cmd_len     (wr_cmd_len),
    .rd_cmd_valid   (rd_cmd_valid),
    .rd_cmd_ready   (rd_cmd_ready),
    .rd_cmd_addr    (rd_cmd_addr),
    .rd_cmd_len     (rd_cmd_len),
    .host_cfg_valid (host_cfg_valid),
    .host_cfg_ready (host_cfg_ready),
    .host_cfg_addr  (host_cfg_addr),
    .host_cfg_data  (host_cfg_data),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_valid      (cfg_valid),
    .busy           (busy),
    .wr_jobs        (wr_jobs),
    .rd_jobs        (rd_jobs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One entry per future cycle on the bus; job beats also mean "not idle".
  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    bit          job;
  } beat_t;

  beat_t sched[$];
  beat_t cur;
  bit    m_last_rd;
  int    m_wr, m_rd;
  bit    acc_w, acc_r, acc_h;
  int    n_checks = 0;
  int    n_fail = 0;

  function automatic logic [31:0] expCount(input int n);
    logic [31:0] r;
    r = 32'(n % (1 << STATW));
`ifndef AXIS_CFG_ARB_STATS_EN
    r = 32'd0;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Moves to the next cycle, retires accepted requests and checks the bus.
  task automatic observeCycle();
    @(negedge clk);
    if (acc_w) wr_cmd_valid = 1'b0;
    if (acc_r) rd_cmd_valid = 1'b0;
    if (acc_h) host_cfg_valid = 1'b0;
    acc_w = 1'b0;
    acc_r = 1'b0;
    acc_h = 1'b0;
    if (sched.size() > 0) cur = sched.pop_front();
    else cur = '{1'b0, 5'd0, 32'd0, 1'b0};
    checkOutput("cfg_valid", 32'(cfg_valid), 32'(cur.v));
    if (cur.v) begin
      checkOutput("cfg_addr", 32'(cfg_addr), 32'(cur.a));
      checkOutput("cfg_data", cfg_data, cur.d);
    end
    checkOutput("busy", 32'(busy), 32'(cur.job));
    if (!cur.job) begin
      checkOutput("wr_jobs", 32'(wr_jobs), expCount(m_wr));
      checkOutput("rd_jobs", 32'(rd_jobs), expCount(m_rd));
    end
  endtask

  // Predicts what the arbiter does with the inputs currently driven.
  task automatic applyStimulus();
    bit          eh, ew, er, pick_rd;
    logic [31:0] la, ll;
    #1;
    eh = 1'b0;
    ew = 1'b0;
    er = 1'b0;
    if (!cur.job) begin
      if (host_cfg_valid) begin
        eh = 1'b1;
        sched.push_back('{1'b1, host_cfg_addr, host_cfg_data, 1'b0});
      end else if (wr_cmd_valid || rd_cmd_valid) begin
        pick_rd = rd_cmd_valid && (!wr_cmd_valid || !m_last_rd);
        ew = !pick_rd;
        er = pick_rd;
        la = pick_rd ? rd_cmd_addr : wr_cmd_addr;
        ll = pick_rd ? rd_cmd_len : wr_cmd_len;
        if (ll != 32'd0) begin
          sched.push_back('{1'b1, 5'd23, la, 1'b1});
          sched.push_back('{1'b1, 5'd24, ll, 1'b1});
          sched.push_back('{1'b1, pick_rd ? 5'd2 : 5'd1, 32'd0, 1'b1});
          m_last_rd = pick_rd;
          if (pick_rd) m_rd++;
          else m_wr++;
        end
      end
    end
    checkOutput("host_cfg_ready", 32'(host_cfg_ready), 32'(eh));
    checkOutput("wr_cmd_ready", 32'(wr_cmd_ready), 32'(ew));
    checkOutput("rd_cmd_ready", 32'(rd_cmd_ready), 32'(er));
    acc_h = eh;
    acc_w = ew;
    acc_r = er;
  endtask

  task automatic genRandom(input int pw, input int pr, input int ph);
    if (!wr_cmd_valid && $urandom_range(0, 99) < pw) begin
      wr_cmd_valid = 1'b1;
      wr_cmd_addr  = $urandom;
      wr_cmd_len   = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
    end
    if (!rd_cmd_valid && $urandom_range(0, 99) < pr) begin
      rd_cmd_valid = 1'b1;
      rd_cmd_addr  = $urandom;
      rd_cmd_len   = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
    end
    if (!host_cfg_valid && $urandom_range(0, 99) < ph) begin
      host_cfg_valid = 1'b1;
      host_cfg_addr  = 5'($urandom_range(0, 31));
      host_cfg_data  = $urandom;
    end
  endtask

  task automatic runCycles(input int n, input int pw, input int pr, input int ph);
    for (int i = 0; i < n; i++) begin
      observeCycle();
      genRandom(pw, pr, ph);
      applyStimulus();
    end
  endtask

  task automatic doReset();
    rst            = 1'b1;
    wr_cmd_valid   = 1'b0;
    rd_cmd_valid   = 1'b0;
    host_cfg_valid = 1'b0;
    acc_w = 1'b0;
    acc_r = 1'b0;
    acc_h = 1'b0;
    @(posedge clk);
    sched.delete();
    m_last_rd = 1'b1;
    m_wr = 0;
    m_rd = 0;
    observeCycle();
    checkOutput("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    checkOutput("rst_cfg_data", cfg_data, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst = 1'b1;
    wr_cmd_valid = 1'b0; wr_cmd_addr = '0; wr_cmd_len = '0;
    rd_cmd_valid = 1'b0; rd_cmd_addr = '0; rd_cmd_len = '0;
    host_cfg_valid = 1'b0; host_cfg_addr = '0; host_cfg_data = '0;
    cur = '{1'b0, 5'd0, 32'd0, 1'b0};
    doReset();

    $display("[TB] single write job");
    observeCycle();
    wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h1000_0000; wr_cmd_len = 32'd64;
    applyStimulus();
    runCycles(5, 0, 0, 0);

    $display("[TB] simultaneous write and read, alternating grants");
    runCycles(26, 100, 100, 0);
    runCycles(4, 0, 0, 0);

    $display("[TB] host beat during LEN");
    observeCycle();
    wr_cmd_valid = 1'b1; wr_cmd_addr = 32'hCAFE_0000; wr_cmd_len = 32'd8;
    applyStimulus();
    observeCycle();
    applyStimulus();
    observeCycle();
    host_cfg_valid = 1'b1; host_cfg_addr = 5'd5; host_cfg_data = 32'hA5;
    rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h2000_0040; rd_cmd_len = 32'd3;
    applyStimulus();
    runCycles(8, 0, 0, 0);

    $display("[TB] zero-length read job");
    observeCycle();
    rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h3000_0000; rd_cmd_len = 32'd0;
    applyStimulus();
    runCycles(3, 0, 0, 0);

    $display("[TB] reset during LEN");
    observeCycle();
    wr_cmd_valid = 1'b1; wr_cmd_addr = 32'h4000_0000; wr_cmd_len = 32'd16;
    applyStimulus();
    observeCycle();
    applyStimulus();
    observeCycle();
    doReset();
    runCycles(3, 0, 0, 0);

    $display("[TB] write counter wrap");
    runCycles(72, 100, 0, 0);
    for (int i = 0; i < 4; i++) begin
      observeCycle();
      if (!wr_cmd_valid) begin
        wr_cmd_valid = 1'b1; wr_cmd_addr = $urandom; wr_cmd_len = 32'd1;
      end
      applyStimulus();
    end
    runCycles(5, 0, 0, 0);

    $display("[TB] random traffic");
    runCycles(800, 30, 30, 10);
    runCycles(6, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
